// File: rtl/clock_ratio_meter.sv
// Measures the average period of the asynchronous clk_meas over 2^FRAC_BITS periods.
// Define CLOCK_RATIO_METER_MINMAX_EN to track the shortest and longest single period.
module clock_ratio_meter #(
  parameter int FRAC_BITS        = 8,
  parameter int COUNT_BITS       = 24,
  parameter int EXPECTED_RATIO_Q = 8940,
  parameter int TOLERANCE_Q      = 26,
  parameter int LOCK_WINDOWS     = 2,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                  clk_src,
  input  logic                  reset,
  input  logic                  clk_meas,
  input  logic                  enable,
  output logic [COUNT_BITS-1:0] ratio_q,
  output logic                  ratio_valid,
  output logic                  locked,
  output logic                  no_clock,
  output logic [COUNT_BITS-1:0] period_min,
  output logic [COUNT_BITS-1:0] period_max
);

  localparam int IDLE_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RUN_BITS  = $clog2(LOCK_WINDOWS + 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, NOCLK} state_t;

  state_t                state, state_next;
  logic                  sync1, sync2, hist;
  logic                  meas_edge;
  logic [COUNT_BITS-1:0] cyc_cnt;
  logic [FRAC_BITS-1:0]  per_cnt;
  logic [IDLE_BITS-1:0]  idle_cnt;
  logic [RUN_BITS-1:0]   run_cnt;
  logic                  sat;
  logic                  start, close, advance, timeout, idle_hit;
  logic [COUNT_BITS:0]   cyc_ext, exp_ext, diff;
  logic                  in_tol;

  assign meas_edge = sync2 & ~hist;
  assign idle_hit  = (idle_cnt == IDLE_BITS'(TIMEOUT_CYCLES - 1));
  assign cyc_ext   = {1'b0, cyc_cnt};
  assign exp_ext   = (COUNT_BITS + 1)'(EXPECTED_RATIO_Q);
  assign diff      = (cyc_ext >= exp_ext) ? (cyc_ext - exp_ext) : (exp_ext - cyc_ext);
  assign in_tol    = !sat && (diff <= (COUNT_BITS + 1)'(TOLERANCE_Q));

  // Next state and per-cycle events; enable low overrides edge and timeout.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    close      = 1'b0;
    advance    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: state_next = ARM;
      ARM, NOCLK: begin
        if (meas_edge) begin
          start      = 1'b1;
          state_next = MEASURE;
        end else if (state == ARM && idle_hit) begin
          timeout    = 1'b1;
          state_next = NOCLK;
        end
      end
      MEASURE: begin
        if (meas_edge) begin
          advance = 1'b1;
          close   = (per_cnt == '1);
        end else if (idle_hit) begin
          timeout    = 1'b1;
          state_next = NOCLK;
        end
      end
    endcase
    if (!enable) begin
      state_next = IDLE;
      start      = 1'b0;
      close      = 1'b0;
      advance    = 1'b0;
      timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk_src) begin
    if (reset) begin
      state       <= IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      hist        <= 1'b0;
      cyc_cnt     <= '0;
      per_cnt     <= '0;
      idle_cnt    <= '0;
      run_cnt     <= '0;
      sat         <= 1'b0;
      ratio_q     <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      no_clock    <= 1'b0;
    end else begin
      sync1       <= clk_meas;
      sync2       <= sync1;
      hist        <= sync2;
      state       <= state_next;
      ratio_valid <= 1'b0;
      if (!enable || state == IDLE) begin
        cyc_cnt  <= '0;
        per_cnt  <= '0;
        idle_cnt <= '0;
        run_cnt  <= '0;
        sat      <= 1'b0;
        locked   <= 1'b0;
        no_clock <= 1'b0;
      end else begin
        if (meas_edge)
          idle_cnt <= '0;
        else if (idle_cnt != IDLE_BITS'(TIMEOUT_CYCLES))
          idle_cnt <= idle_cnt + 1'b1;
        // A closing edge also opens the next window, so no cycle is lost.
        if (start) begin
          cyc_cnt  <= COUNT_BITS'(1);
          per_cnt  <= '0;
          sat      <= 1'b0;
          no_clock <= 1'b0;
        end else if (close) begin
          ratio_q     <= sat ? '1 : cyc_cnt;
          ratio_valid <= 1'b1;
          cyc_cnt     <= COUNT_BITS'(1);
          sat         <= 1'b0;
          per_cnt     <= per_cnt + 1'b1;
          if (in_tol) begin
            if (run_cnt != RUN_BITS'(LOCK_WINDOWS))
              run_cnt <= run_cnt + 1'b1;
            locked <= (run_cnt >= RUN_BITS'(LOCK_WINDOWS - 1));
          end else begin
            run_cnt <= '0;
            locked  <= 1'b0;
          end
        end else if (state == MEASURE) begin
          if (advance)
            per_cnt <= per_cnt + 1'b1;
          if (cyc_cnt == '1)
            sat <= 1'b1;
          else
            cyc_cnt <= cyc_cnt + 1'b1;
        end
        if (timeout) begin
          no_clock <= 1'b1;
          locked   <= 1'b0;
          run_cnt  <= '0;
        end
      end
    end
  end

`ifdef CLOCK_RATIO_METER_MINMAX_EN
  logic [COUNT_BITS-1:0] last_period;
  logic                  period_new;

  // idle_cnt at an edge is one less than the edge-to-edge distance.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      period_min  <= '1;
      period_max  <= '0;
      last_period <= '0;
      period_new  <= 1'b0;
    end else begin
      period_new  <= (state == MEASURE) && advance;
      last_period <= COUNT_BITS'(idle_cnt) + COUNT_BITS'(1);
      if (state == IDLE && state_next == ARM) begin
        period_min <= '1;
        period_max <= '0;
      end else if (period_new) begin
        if (last_period < period_min)
          period_min <= last_period;
        if (last_period > period_max)
          period_max <= last_period;
      end
    end
  end
`else
  assign period_min = '0;
  assign period_max = '0;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter: timestamp-based model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_clock_ratio_meter;

  localparam int WIN   = 256;
  localparam int EXP   = 8940;
  localparam int TOL   = 26;
  localparam int LOCKW = 2;
  localparam int TMO   = 4096;

  logic        clk_src  = 1'b0;
  logic        reset    = 1'b1;
  logic        clk_meas = 1'b0;
  logic        enable   = 1'b0;
  logic [23:0] ratio_q, period_min, period_max;
  logic        ratio_valid, locked, no_clock;

  clock_ratio_meter #(
    .FRAC_BITS(8), .COUNT_BITS(24), .EXPECTED_RATIO_Q(EXP), .TOLERANCE_Q(TOL),
    .LOCK_WINDOWS(LOCKW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_src(clk_src), .reset(reset), .clk_meas(clk_meas), .enable(enable),
    .ratio_q(ratio_q), .ratio_valid(ratio_valid), .locked(locked), .no_clock(no_clock),
    .period_min(period_min), .period_max(period_max)
  );

  always #5 clk_src = ~clk_src;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_on = 0;
  bit edge_due[int];
  int last_rise = 0;

  // Model: edge timestamps in clk_src cycles, window = time between edge k and edge k+256.
  typedef enum int {M_IDLE, M_ARM, M_MEAS, M_NOCLK} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_last_t = 0, m_win_t = 0, m_edges = 0, m_run = 0;
  int    m_ratio = 0;
  bit    m_valid = 0, m_locked = 0, m_noclk = 0;

  always @(posedge clk_src) begin
    int ratio, diff;
    bit e, sat;
    cyc++;
    e = edge_due.exists(cyc);
    m_valid = 0;
    if (reset) begin
      m_mode = M_IDLE; m_ratio = 0; m_locked = 0; m_noclk = 0; m_run = 0;
    end else if (!enable) begin
      m_mode = M_IDLE; m_locked = 0; m_noclk = 0; m_run = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_ARM; m_last_t = cyc; end
        M_ARM, M_NOCLK: begin
          if (e) begin
            m_mode = M_MEAS; m_win_t = cyc; m_edges = 0; m_last_t = cyc; m_noclk = 0;
          end else if (m_mode == M_ARM && cyc - m_last_t >= TMO) begin
            m_mode = M_NOCLK; m_noclk = 1; m_locked = 0; m_run = 0;
          end
        end
        M_MEAS: begin
          if (e) begin
            m_edges++;
            m_last_t = cyc;
            if (m_edges == WIN) begin
              ratio = cyc - m_win_t;
              sat = (ratio > 24'hFFFFFF);
              m_ratio = sat ? 24'hFFFFFF : ratio;
              m_valid = 1;
              diff = (ratio > EXP) ? ratio - EXP : EXP - ratio;
              if (!sat && diff <= TOL) begin
                if (m_run < LOCKW) m_run++;
                m_locked = (m_run >= LOCKW);
              end else begin
                m_run = 0; m_locked = 0;
              end
              m_win_t = cyc;
              m_edges = 0;
            end
          end else if (cyc - m_last_t >= TMO) begin
            m_mode = M_NOCLK; m_noclk = 1; m_locked = 0; m_run = 0;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  int  valid_count = 0, last_valid_cyc = 0, prev_valid_cyc = 0, first_valid_cyc = 0;
  int  first_lock_valid = 0, noclk_rise_cyc = -1;
  bit  prev_noclk = 0;

  always @(negedge clk_src) begin
    if (cmp_on) begin
      checkOutput("ratio_q", 32'(ratio_q), 32'(m_ratio));
      checkOutput("ratio_valid", 32'(ratio_valid), 32'(m_valid));
      checkOutput("locked", 32'(locked), 32'(m_locked));
      checkOutput("no_clock", 32'(no_clock), 32'(m_noclk));
      if (ratio_valid === 1'b1) begin
        valid_count++;
        if (valid_count == 1) first_valid_cyc = cyc;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        if (locked === 1'b1 && first_lock_valid == 0) first_lock_valid = valid_count;
      end
      if (no_clock === 1'b1 && !prev_noclk) noclk_rise_cyc = cyc;
      prev_noclk = (no_clock === 1'b1);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk_src);
      #1;
    end
  endtask

  // Each rise is seen by the meter three clk_src edges later (2-flop sync + history flop).
  task automatic applyStimulus(input int count, input int pa, input int pb);
    int p;
    for (int i = 0; i < count; i++) begin
      p = (i % 2 == 0) ? pa : pb;
      clk_meas = 1'b1;
      edge_due[cyc + 3] = 1;
      last_rise = cyc;
      wait_cycles(p / 2);
      clk_meas = 1'b0;
      wait_cycles(p - p / 2);
    end
  endtask

  task automatic clear_monitor();
    valid_count = 0; first_lock_valid = 0; first_valid_cyc = 0;
    last_valid_cyc = 0; prev_valid_cyc = 0;
  endtask

  int en_rise;

  initial begin
    @(posedge clk_src);
    #1;
    cmp_on = 1;
    wait_cycles(4);
    checkOutput("rst_ratio_q", 32'(ratio_q), 0);
    checkOutput("rst_valid", 32'(ratio_valid), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_no_clock", 32'(no_clock), 0);
`ifdef CLOCK_RATIO_METER_MINMAX_EN
    checkOutput("rst_period_min", 32'(period_min), 32'h00FF_FFFF);
`else
    checkOutput("rst_period_min", 32'(period_min), 0);
`endif
    checkOutput("rst_period_max", 32'(period_max), 0);

    reset = 1'b0;
    enable = 1'b1;
    wait_cycles(5);

    clear_monitor();
    applyStimulus(2 * WIN + 10, 35, 35);
    checkOutput("p35_valid_count", valid_count, 2);
    checkOutput("p35_ratio_q", 32'(ratio_q), 8960);
    checkOutput("p35_lock_at_valid", first_lock_valid, 2);
    checkOutput("p35_valid_spacing", last_valid_cyc - prev_valid_cyc, 8960);
    checkOutput("p35_no_clock", 32'(no_clock), 0);

    wait_cycles(TMO + 100);
    checkOutput("noclk_flag", 32'(no_clock), 1);
    checkOutput("noclk_locked", 32'(locked), 0);
    checkOutput("noclk_ratio_hold", 32'(ratio_q), 8960);
    checkOutput("noclk_delay", noclk_rise_cyc - (last_rise + 3), TMO);

    clear_monitor();
    applyStimulus(2 * WIN + 10, 35, 35);
    checkOutput("restart_no_clock", 32'(no_clock), 0);
    checkOutput("restart_valid_count", valid_count, 2);
    checkOutput("restart_lock_at_valid", first_lock_valid, 2);
    checkOutput("restart_ratio_q", 32'(ratio_q), 8960);

    applyStimulus(60, 35, 35);
    checkOutput("predrop_locked", 32'(locked), 1);
    enable = 1'b0;
    clear_monitor();
    applyStimulus(3, 35, 35);
    checkOutput("drop_valid_count", valid_count, 0);
    checkOutput("drop_locked", 32'(locked), 0);
    checkOutput("drop_ratio_hold", 32'(ratio_q), 8960);
    enable = 1'b1;
    en_rise = cyc;
    applyStimulus(WIN + 10, 35, 35);
    checkOutput("reen_valid_count", valid_count, 1);
    checkOutput("reen_valid_delay", first_valid_cyc - en_rise, 3 + 8960);
    checkOutput("reen_locked", 32'(locked), 0);

    enable = 1'b0;
    wait_cycles(2);
    enable = 1'b1;
    wait_cycles(2);
    clear_monitor();
    applyStimulus(2 * WIN + 4, 34, 35);
    checkOutput("alt_valid_count", valid_count, 2);
    checkOutput("alt_ratio_q", 32'(ratio_q), 8832);
    checkOutput("alt_valid_spacing", last_valid_cyc - prev_valid_cyc, 8832);
    checkOutput("alt_locked", 32'(locked), 0);

    wait_cycles(20);
    reset = 1'b1;
    wait_cycles(1);
    checkOutput("midrst_ratio_q", 32'(ratio_q), 0);
    checkOutput("midrst_valid", 32'(ratio_valid), 0);
    checkOutput("midrst_locked", 32'(locked), 0);
    checkOutput("midrst_no_clock", 32'(no_clock), 0);
    reset = 1'b0;
    wait_cycles(3);

    applyStimulus(12, 34, 36);
    wait_cycles(5);
`ifdef CLOCK_RATIO_METER_MINMAX_EN
    checkOutput("mm_period_min", 32'(period_min), 34);
    checkOutput("mm_period_max", 32'(period_max), 36);
`else
    checkOutput("mm_period_min", 32'(period_min), 0);
    checkOutput("mm_period_max", 32'(period_max), 0);
`endif

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
